// File: rtl/seq_detect_arbiter_if.sv
// rtl/seq_detect_arbiter_if.sv - requester, detector and status signals of seq_detect_arbiter
interface seq_detect_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [4*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [3:0]         det_number;
    logic               det_valid;
    logic               det_clear;
    logic               det_pattern;
    logic [N_REQ-1:0]   match_valid;
    logic [2:0]         grant_id;
    logic               busy;

    modport master (
        input  req_valid, req_data, req_last, det_pattern,
        output req_ready, det_number, det_valid, det_clear, match_valid, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, req_last, det_pattern,
        input  req_ready, det_number, det_valid, det_clear, match_valid, grant_id, busy
    );
endinterface

// File: rtl/seq_detect_arbiter.sv
// rtl/seq_detect_arbiter.sv - round-robin burst arbiter sharing one sequence detector
// Optional per-grant nibble limit: SEQ_ARB_BURST_LIMIT_EN.
module seq_detect_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DET_LATENCY = 1,
    parameter int MAX_BURST   = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    seq_detect_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_t;

    localparam int DW = $clog2(DET_LATENCY + 1);

    state_t                      state_q, state_d;
    logic [2:0]                  rr_ptr_q, rr_ptr_d;
    logic [2:0]                  grant_id_q, grant_id_d;
    logic [3:0]                  det_number_q, det_number_d;
    logic                        det_valid_q, det_valid_d;
    logic [DW-1:0]               drain_cnt_q, drain_cnt_d;
    logic [DET_LATENCY-1:0]      tag_v_q, tag_v_d;
    logic [DET_LATENCY-1:0][2:0] tag_id_q, tag_id_d;
    logic [N_REQ-1:0]            match_valid_q, match_valid_d;

    logic                        sel_valid, sel_last, accept, found, burst_end;
    logic [3:0]                  sel_data;
    logic [2:0]                  pick;
    logic [N_REQ-1:0]            ready;
    int                          best_dist;

`ifdef SEQ_ARB_BURST_LIMIT_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;

    assign burst_end = (burst_cnt_q == BW'(MAX_BURST - 1));

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (state_q == CLEAR) begin
            burst_cnt_d = '0;
        end else if (accept) begin
            burst_cnt_d = burst_cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    logic unused_max_burst;
    assign unused_max_burst = (MAX_BURST > 0);
    assign burst_end        = 1'b0;
`endif

    // Owner's lane, selected without a variable part-select on the bus vectors.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        ready     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id_q == 3'(i)) begin
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
                sel_data  = bus.req_data[4*i +: 4];
                ready[i]  = (state_q == STREAM);
            end
        end
    end

    assign accept = (state_q == STREAM) && sel_valid;

    // Round-robin pick: smallest rotated distance from rr_ptr wins.
    always_comb begin
        best_dist = N_REQ;
        pick      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.req_valid[i] && (((i - int'(rr_ptr_q) + N_REQ) % N_REQ) < best_dist)) begin
                best_dist = (i - int'(rr_ptr_q) + N_REQ) % N_REQ;
                pick      = 3'(i);
            end
        end
        found = (best_dist < N_REQ);
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        drain_cnt_d  = drain_cnt_q;
        det_valid_d  = accept;
        det_number_d = accept ? sel_data : det_number_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d = pick;
                    state_d    = CLEAR;
                end
            end
            CLEAR: state_d = STREAM;
            STREAM: begin
                if (accept && (sel_last || burst_end)) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DW'(DET_LATENCY)) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_id_q == 3'(N_REQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag each presented nibble with its owner so a late hit finds its way home.
    always_comb begin
        tag_v_d     = '0;
        tag_id_d    = '0;
        tag_v_d[0]  = det_valid_q;
        tag_id_d[0] = grant_id_q;
        for (int i = 1; i < DET_LATENCY; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
        match_valid_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            match_valid_d[i] = tag_v_q[DET_LATENCY-1] && bus.det_pattern &&
                               (tag_id_q[DET_LATENCY-1] == 3'(i));
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            det_number_q  <= '0;
            det_valid_q   <= 1'b0;
            drain_cnt_q   <= '0;
            tag_v_q       <= '0;
            tag_id_q      <= '0;
            match_valid_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            det_number_q  <= det_number_d;
            det_valid_q   <= det_valid_d;
            drain_cnt_q   <= drain_cnt_d;
            tag_v_q       <= tag_v_d;
            tag_id_q      <= tag_id_d;
            match_valid_q <= match_valid_d;
        end
    end

    assign bus.req_ready   = ready;
    assign bus.det_number  = det_number_q;
    assign bus.det_valid   = det_valid_q;
    assign bus.det_clear   = (state_q == CLEAR);
    assign bus.match_valid = match_valid_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_seq_detect_arbiter.sv
// tb/tb_seq_detect_arbiter.sv - randomized and directed bench for seq_detect_arbiter
module tb_seq_detect_arbiter;
    localparam int N  = 4;
    localparam int DL = 2;
`ifdef SEQ_ARB_BURST_LIMIT_EN
    localparam int MAXB  = 4;
    localparam bit LIMIT = 1'b1;
`else
    localparam int MAXB  = 16;
    localparam bit LIMIT = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    seq_detect_arbiter_if #(.N_REQ(N)) dut_if ();

    seq_detect_arbiter #(.N_REQ(N), .DET_LATENCY(DL), .MAX_BURST(MAXB)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (dut_if)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: phase 0 idle, 1 clear, 2 stream, 3 drain.
    int         m_phase, m_owner, m_rr, m_drain_left, m_cnt, last_rst;
    logic       m_dv;
    logic [3:0] m_num;
    logic [N-1:0] m_match;
    bit         model_ok = 1'b0;
    bit         hv[int];
    int         ho[int];

    logic [4:0] rq [N][$];
    int         mode = 0;
    bit         throttle = 1'b0;
    bit         hit_at[int];
    logic [15:0] dhist = '0;
    int         dcount = 0;
    int         clr_log[$], num_log[$], match_log[$], match_cyc[$], acc0_cyc[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    always @(posedge clock) begin : model
        int src;
        bit acc, found;
        hv[cyc] = m_dv;
        ho[cyc] = m_owner;
        if (!reset_n) begin
            m_phase = 0; m_rr = 0; m_owner = 0; m_dv = 1'b0; m_num = '0;
            m_match = '0; m_drain_left = 0; m_cnt = 0; last_rst = cyc; model_ok = 1'b1;
        end else begin
            src = cyc - DL;
            m_match = '0;
            if (src > last_rst && hv.exists(src) && hv[src] && dut_if.det_pattern)
                m_match[ho[src]] = 1'b1;
            acc = (m_phase == 2) && dut_if.req_valid[m_owner];
            m_dv = acc;
            if (acc) m_num = dut_if.req_data[4*m_owner +: 4];
            case (m_phase)
                0: begin
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && dut_if.req_valid[(m_rr + k) % N]) begin
                            found = 1'b1;
                            m_owner = (m_rr + k) % N;
                            m_phase = 1;
                        end
                    end
                end
                1: begin m_phase = 2; m_cnt = 0; end
                2: if (acc) begin
                    m_cnt++;
                    if (dut_if.req_last[m_owner] || (LIMIT && m_cnt == MAXB)) begin
                        m_phase = 3;
                        m_drain_left = DL + 1;
                    end
                end
                default: begin
                    m_drain_left--;
                    if (m_drain_left == 0) begin
                        m_rr = (m_owner + 1) % N;
                        m_phase = 0;
                    end
                end
            endcase
        end
        cyc++;
    end

    always @(negedge clock) begin
        if (model_ok) begin
            chk("busy",        32'(dut_if.busy),        32'(m_phase != 0));
            chk("req_ready",   32'(dut_if.req_ready),   (m_phase == 2) ? (32'd1 << m_owner) : 32'd0);
            chk("det_clear",   32'(dut_if.det_clear),   32'(m_phase == 1));
            chk("det_valid",   32'(dut_if.det_valid),   32'(m_dv));
            chk("det_number",  32'(dut_if.det_number),  32'(m_num));
            chk("match_valid", 32'(dut_if.match_valid), 32'(m_match));
            if (m_phase != 0) chk("grant_id", 32'(dut_if.grant_id), 32'(m_owner));
        end
        if (dut_if.det_clear === 1'b1) clr_log.push_back(int'(dut_if.grant_id));
        if (dut_if.det_valid === 1'b1) num_log.push_back(int'(dut_if.det_number));
        if (dut_if.match_valid !== '0) begin
            match_log.push_back(int'(dut_if.match_valid));
            match_cyc.push_back(cyc);
        end
    end

    task automatic push_nib(input int r, input int v, input bit last);
        rq[r].push_back({last, 4'(v)});
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0 && (!throttle || $urandom_range(0, 3) != 0)) begin
                dut_if.req_valid[i]        = 1'b1;
                dut_if.req_data[4*i +: 4]  = rq[i][0][3:0];
                dut_if.req_last[i]         = rq[i][0][4];
            end else begin
                dut_if.req_valid[i]        = 1'b0;
                dut_if.req_data[4*i +: 4]  = 4'($urandom);
                dut_if.req_last[i]         = 1'($urandom);
            end
        end
    endtask

    // Stand-in detector: decides hits from what the DUT presents, DL cycles later.
    task automatic detect();
        bit hit = 1'b0;
        if (dut_if.det_clear === 1'b1) begin dhist = '0; dcount = 0; end
        if (dut_if.det_valid === 1'b1) begin
            dhist = {dhist[11:0], dut_if.det_number};
            dcount++;
            if (mode == 1) hit = (dcount >= 4) && (dhist == 16'h1094);
            if (mode == 2) hit = (dut_if.det_number == 4'd4);
        end
        hit_at[cyc] = hit;
        case (mode)
            0:       dut_if.det_pattern = ($urandom_range(0, 2) == 0);
            3:       dut_if.det_pattern = 1'b1;
            default: dut_if.det_pattern = hit_at.exists(cyc - DL) ? hit_at[cyc - DL] : 1'b0;
        endcase
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        int acyc;
        @(negedge clock);
        acc  = dut_if.req_ready & dut_if.req_valid;
        acyc = cyc;
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (reset_n && acc[i] === 1'b1 && rq[i].size() > 0) begin
                if (i == 0) acc0_cyc.push_back(acyc);
                rq[i].delete(0);
            end
        end
        detect();
        drive();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_logs();
        clr_log.delete(); num_log.delete(); match_log.delete();
        match_cyc.delete(); acc0_cyc.delete();
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = all_empty() && (dut_if.busy === 1'b0);
        end
        chk({name, "_completes"}, 32'(done), 32'd1);
        repeat (4) tick();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) rq[i].delete();
        reset_n = 1'b0;
        drive();
        tick();
        tick();
        reset_n = 1'b1;
        clear_logs();
    endtask

    initial begin
        int exp_num[$];
        int exp_clr[$];
        int n;
        reset_n = 1'b0;
        dut_if.det_pattern = 1'b0;
        for (int i = 0; i < N; i++) push_nib(i, i + 1, 1'b1);
        drive();

        // Reset with all requesters valid.
        mode = 1;
        tick();
        tick();
        chk("rst_req_ready",   32'(dut_if.req_ready),   32'd0);
        chk("rst_det_valid",   32'(dut_if.det_valid),   32'd0);
        chk("rst_det_clear",   32'(dut_if.det_clear),   32'd0);
        chk("rst_match_valid", 32'(dut_if.match_valid), 32'd0);
        chk("rst_busy",        32'(dut_if.busy),        32'd0);
        reset_n = 1'b1;
        clear_logs();
        run_until_idle("rst", 200);
        chk("rst_first_grant", (clr_log.size() > 0) ? clr_log[0] : -1, 32'd0);
        chk("rst_grant_count", clr_log.size(), 32'd4);

        // Single stream 1,0,9,4 with a real pattern hit on the 4.
        do_reset();
        mode = 1;
        push_nib(0, 1, 0); push_nib(0, 0, 0); push_nib(0, 9, 0); push_nib(0, 4, 1);
        run_until_idle("single", 100);
        chk("single_clears", clr_log.size(), 32'd1);
        exp_num = '{1, 0, 9, 4};
        chk("single_num_count", num_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < num_log.size(); i++) chk("single_num", num_log[i], exp_num[i]);
        chk("single_match_count", match_log.size(), 32'd1);
        if (match_log.size() == 1 && acc0_cyc.size() > 0) begin
            chk("single_match_val", match_log[0], 32'h1);
            chk("single_match_lat", match_cyc[0] - acc0_cyc[acc0_cyc.size() - 1], 32'(DL + 2));
        end

        // Round-robin with all requesters holding 2-nibble bursts.
        do_reset();
        mode = 0;
        push_nib(0, 2, 0); push_nib(0, 3, 1); push_nib(0, 4, 0); push_nib(0, 5, 1);
        push_nib(1, 6, 0); push_nib(1, 7, 1);
        push_nib(2, 8, 0); push_nib(2, 9, 1);
        push_nib(3, 10, 0); push_nib(3, 11, 1);
        run_until_idle("rr", 300);
        exp_clr = '{0, 1, 2, 3, 0};
        chk("rr_clear_count", clr_log.size(), 32'd5);
        for (int i = 0; i < 5 && i < clr_log.size(); i++) chk("rr_order", clr_log[i], exp_clr[i]);

        // Isolation: the hit on req2's 4 must not reach req1.
        do_reset();
        mode = 2;
        push_nib(1, 1, 0); push_nib(1, 0, 1);
        push_nib(2, 9, 0); push_nib(2, 4, 1);
        run_until_idle("iso", 200);
        chk("iso_match_count", match_log.size(), 32'd1);
        if (match_log.size() > 0) chk("iso_match_val", match_log[0], 32'h4);
        n = 0;
        foreach (match_log[i]) if (match_log[i][1]) n++;
        chk("iso_no_req1", n, 32'd0);

        // Reset in the middle of a stream.
        do_reset();
        mode = 3;
        for (int k = 0; k < 6; k++) push_nib(0, k + 3, k == 5);
        n = 0;
        while (acc0_cyc.size() < 2 && n < 30) begin tick(); n++; end
        chk("midrst_two_accepted", acc0_cyc.size(), 32'd2);
        for (int i = 0; i < N; i++) rq[i].delete();
        drive();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midrst_busy",      32'(dut_if.busy),      32'd0);
        chk("midrst_req_ready", 32'(dut_if.req_ready), 32'd0);
        chk("midrst_det_valid", 32'(dut_if.det_valid), 32'd0);
        match_log.delete();
        repeat (8) tick();
        chk("midrst_no_match", match_log.size(), 32'd0);
        chk("midrst_stays_idle", 32'(dut_if.busy), 32'd0);

`ifdef SEQ_ARB_BURST_LIMIT_EN
        // Burst limit of 4 splits a 6-nibble burst around req1.
        do_reset();
        mode = 0;
        for (int k = 0; k < 6; k++) push_nib(0, k + 1, k == 5);
        push_nib(1, 7, 0); push_nib(1, 8, 1);
        run_until_idle("limit", 300);
        exp_clr = '{0, 1, 0};
        chk("limit_clear_count", clr_log.size(), 32'd3);
        for (int i = 0; i < 3 && i < clr_log.size(); i++) chk("limit_order", clr_log[i], exp_clr[i]);
        exp_num = '{1, 2, 3, 4, 7, 8, 5, 6};
        chk("limit_num_count", num_log.size(), 32'd8);
        for (int i = 0; i < 8 && i < num_log.size(); i++) chk("limit_num", num_log[i], exp_num[i]);
`endif

        // Random traffic, throttled valids and random hits, checked by the model.
        do_reset();
        mode = 0;
        throttle = 1'b1;
        for (int t = 0; t < 2500; t++) begin
            if ($urandom_range(0, 5) == 0) begin
                int r, len;
                r   = $urandom_range(0, N - 1);
                len = $urandom_range(1, 6);
                if (rq[r].size() < 12)
                    for (int k = 0; k < len; k++) push_nib(r, $urandom_range(0, 15), k == len - 1);
            end
            tick();
        end
        run_until_idle("random", 3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
